uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
Serial receive engine of the UART core. It sits between the `rxd` pad input and the RX FIFO.
- Synchronises and oversamples `rxd`.
- Validates the start bit and majority-votes each bit.
- Deserialises 8N1 frames, LSB first.
- Pushes each good byte to the FIFO as a single-cycle write strobe.

Parameters:
- CLK_DIV, 65, clk cycles per oversample tick (10 MHz / (9600 × 16)).
- OVS, 16, oversample ticks per bit; must be even and ≥ 8.

Ports:
- clk  input  1  system clock, 10 MHz.
- rst  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial line; idle high.
- rx_full  input  1  downstream FIFO full.
- rx_data  output  8  last accepted byte.
- rx_valid  output  1  one-cycle write strobe to the FIFO.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun_err  output  1  one-cycle pulse: good byte dropped because rx_full=1.
- parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 without the macro.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - state=IDLE; all counters=0.
  - Synchroniser flops=1.
  - rx_data=8'h00; rx_valid, frame_err, overrun_err, parity_err, busy = 0.
  - rst has priority over every other event, including mid-frame: the partial frame is discarded and no pulse is emitted.
- Synchroniser: two-flop chain on rxd, reset value 1. All logic below uses the synchronised bit `rxs`.
- Tick generator:
  - tick_cnt runs 0..CLK_DIV-1; `tick` is high for one cycle when tick_cnt==CLK_DIV-1.
  - tick_cnt is cleared in IDLE and on start detection.
- Sample counter: samp_cnt runs 0..OVS-1 and advances on each tick.
- Voting:
  - rxs is captured on ticks where samp_cnt = OVS/2-1, OVS/2 and OVS/2+1.
  - The bit value is the majority of these 3 samples.
- State machine:
  - IDLE: on rxs==0 (falling edge relative to the idle-high line), clear tick_cnt and samp_cnt and go to START.
  - START: at the tick with samp_cnt==OVS/2+1:
    - vote==1: false start; go to IDLE with no output.
    - vote==0: continue. At the tick with samp_cnt==OVS-1, go to DATA with bit_idx=0.
  - DATA:
    - At vote resolution, the vote is shifted into shreg, LSB first.
    - At samp_cnt==OVS-1: if bit_idx==7, go to PARITY (macro on) or STOP; otherwise bit_idx++.
  - PARITY (macro only): resolve the vote, then advance at samp_cnt==OVS-1.
  - STOP: resolve at samp_cnt==OVS/2+1, then go immediately to IDLE. The second half of the stop bit is not waited out, so a start edge in the very next bit period is detected.
- Completion, in the same cycle STOP resolves. Exactly one of the following, checked in priority order:
  - stop vote 0: frame_err pulse.
  - parity mismatch: parity_err pulse.
  - rx_full=1: overrun_err pulse.
  - otherwise: rx_data<=shreg, and rx_valid pulses in the following cycle (registered), with rx_data stable from that cycle on.
- rx_data changes only on accepted bytes.
- Latency: from the first synchronised low of the start bit to rx_valid = (9×OVS + OVS/2+1)×CLK_DIV + 1 clk cycles, ±1 tick.
- rxd held low continuously (break):
  - frame_err pulses once.
  - No new frame begins until rxs has been seen high in IDLE; IDLE requires a 1→0 transition.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP (frame 8E1).
  - Expected parity = ^shreg (even).
  - A mismatch yields a parity_err pulse and the byte is not written.
- Undefined:
  - 8N1 frame; parity_err is a constant 0.
  - The PARITY state and its logic are absent.

Test Plan:
- Frame 0xA5 at 1040 clk/bit, rx_full=0 → exactly one rx_valid pulse; rx_data=8'hA5; busy low after STOP; no error pulses.
- rxd low glitch of 300 clk then high → START votes 1; busy returns to 0; rx_valid/frame_err never pulse; rx_data unchanged.
- Frame 0x3C with stop bit driven low → frame_err one pulse; rx_valid stays 0; rx_data keeps previous value.
- Frame 0x7E with rx_full=1 → overrun_err one pulse, no rx_valid. Then 0x81 with rx_full=0 → rx_valid, rx_data=8'h81.
- Back-to-back frames 0x00 then 0xFF with zero idle gap → two rx_valid pulses, 0x00 then 0xFF. Assert rst for 1 cycle mid-way through a third frame → all outputs at reset values; no pulse from that frame.
- With UART_RX_PARITY_EN: frame 0x07 with parity bit 0 (wrong; expected 1) → parity_err pulse, no rx_valid. The same frame with parity 1 → rx_valid, rx_data=8'h07.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receive engine. Synchronises and oversamples rxd,
// majority-votes each bit and deserialises 8N1 frames (8E1 when the
// UART_RX_PARITY_EN macro is defined), LSB first.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   rxd          - asynchronous serial line, idle high
//   rx_full      - downstream FIFO full
//   rx_data      - last accepted byte
//   rx_valid     - one-cycle FIFO write strobe
//   frame_err    - one-cycle pulse, stop bit sampled low
//   overrun_err  - one-cycle pulse, good byte dropped (rx_full=1)
//   parity_err   - one-cycle pulse, parity mismatch (0 without macro)
//   busy         - high whenever the receiver is not idle
module uart_rx_core #(
    parameter int CLK_DIV = 65,
    parameter int OVS     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = $clog2(OVS);

    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVS - 1);
    localparam logic [SW-1:0] S_V0      = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_V1      = SW'(OVS / 2);
    localparam logic [SW-1:0] S_V2      = SW'(OVS / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t state;
    state_t state_next;

    logic          sync1;
    logic          rxs;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] samp_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          smp0;
    logic          smp1;
    logic          armed;

    logic tick;
    logic vote;
    logic at_res;
    logic at_end;
    logic start_det;
    logic shift_en;
    logic bit_inc;
    logic done;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_cap;
`endif

    assign tick   = (state != S_IDLE) && (tick_cnt == TICK_LAST);
    // Third sample is the live rxs on the resolving tick
    assign vote   = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
    assign at_res = tick && (samp_cnt == S_V2);
    assign at_end = tick && (samp_cnt == S_LAST);
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        bit_inc    = 1'b0;
        done       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap    = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                // armed: the line was seen high, so this is a real 1->0 edge
                if (armed && !rxs) begin
                    start_det  = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (at_res && vote) begin
                    state_next = S_IDLE;
                end else if (at_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                shift_en = at_res;
                if (at_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                par_cap = at_res;
                if (at_end) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave mid stop bit so the next start edge is not missed
                if (at_res) begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b1;
            rxs         <= 1'b1;
            tick_cnt    <= '0;
            samp_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            smp0        <= 1'b0;
            smp1        <= 1'b0;
            armed       <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            sync1       <= rxd;
            rxs         <= sync1;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (state == S_IDLE) begin
                tick_cnt <= '0;
                samp_cnt <= '0;
                bit_idx  <= '0;
                armed    <= start_det ? 1'b0 : (armed | rxs);
            end else begin
                armed    <= 1'b0;
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) begin
                    samp_cnt <= (samp_cnt == S_LAST) ? '0
                              : samp_cnt + 1'b1;
                end
            end
            if (tick && samp_cnt == S_V0) begin
                smp0 <= rxs;
            end
            if (tick && samp_cnt == S_V1) begin
                smp1 <= rxs;
            end
            if (bit_inc) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shreg <= {vote, shreg[7:1]};
            end
`ifdef UART_RX_PARITY_EN
            if (par_cap) begin
                par_bit <= vote;
            end
`endif
            if (done) begin
                if (!vote) begin
                    frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                end else if (par_bit != ^shreg) begin
                    parity_err <= 1'b1;
`endif
                end else if (rx_full) begin
                    overrun_err <= 1'b1;
                end else begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core.
// Drives hand-built serial frames and checks pulses and captured data.
module tb_uart_rx_core;

    localparam int CD  = 8;
    localparam int OV  = 16;
    localparam int BIT = CD * OV;
`ifdef UART_RX_PARITY_EN
    localparam int NB  = 10;
`else
    localparam int NB  = 9;
`endif
    localparam int LAT = (NB * OV + OV / 2 + 1) * CD + 3;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       rx_full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;
    logic       busy;

    int checks;
    int failures;
    int cyc;
    int n_valid;
    int n_ferr;
    int n_ovr;
    int n_perr;
    int last_vcyc;
    logic [7:0] vq [$];

    uart_rx_core #(
        .CLK_DIV(CD),
        .OVS    (OV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rx_full    (rx_full),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        n_valid = 0;
        n_ferr  = 0;
        n_ovr   = 0;
        n_perr  = 0;
        last_vcyc = 0;
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            vq.push_back(rx_data);
            n_valid   = n_valid + 1;
            last_vcyc = cyc;
        end
        if (frame_err)   n_ferr = n_ferr + 1;
        if (overrun_err) n_ovr  = n_ovr + 1;
        if (parity_err)  n_perr = n_perr + 1;
    end

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d,
                              input logic stop_b,
                              input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_b);
`else
        if (par_b === 1'bx) $display("note: par_b unknown");
`endif
        send_bit(stop_b);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        rx_full = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", rx_data);
        end
        checks++;
        if ({rx_valid, frame_err, overrun_err, parity_err, busy}
            !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                {rx_valid, frame_err, overrun_err, parity_err, busy});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int v0, e0, t0, lat;
        v0 = n_valid;
        e0 = n_ferr + n_ovr + n_perr;
        t0 = cyc;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        repeat (4) @(negedge clk);
        lat = last_vcyc - t0;
        checks++;
        if (n_valid - v0 !== 1) begin
            failures++;
            $display("FAIL basic_cnt got=%0d exp=1", n_valid - v0);
        end
        checks++;
        if (vq.size() <= v0 || vq[v0] !== 8'hA5) begin
            failures++;
            $display("FAIL basic_data got=%h exp=a5", rx_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy got=%b exp=0", busy);
        end
        checks++;
        if (n_ferr + n_ovr + n_perr - e0 !== 0) begin
            failures++;
            $display("FAIL basic_err got=%0d exp=0",
                n_ferr + n_ovr + n_perr - e0);
        end
        checks++;
        if (lat < LAT - CD - 2 || lat > LAT + CD + 2) begin
            failures++;
            $display("FAIL basic_lat got=%0d exp=%0d", lat, LAT);
        end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy1 got=%b exp=1", busy);
        end
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy0 got=%b exp=0", busy);
        end
        checks++;
        if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin
            failures++;
            $display("FAIL glitch_pulse got=%0d/%0d exp=0/0",
                n_valid - v0, n_ferr - f0);
        end
        checks++;
        if (rx_data !== 8'hA5) begin
            failures++;
            $display("FAIL glitch_data got=%h exp=a5", rx_data);
        end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        repeat (BIT) @(negedge clk);
        checks++;
        if (n_ferr - f0 !== 1) begin
            failures++;
            $display("FAIL ferr_cnt got=%0d exp=1", n_ferr - f0);
        end
        checks++;
        if (n_valid - v0 !== 0) begin
            failures++;
            $display("FAIL ferr_valid got=%0d exp=0", n_valid - v0);
        end
        checks++;
        if (rx_data !== 8'hA5) begin
            failures++;
            $display("FAIL ferr_data got=%h exp=a5", rx_data);
        end
    endtask

    task automatic test_overrun();
        int v0, o0;
        v0 = n_valid;
        o0 = n_ovr;
        rx_full = 1'b1;
        send_frame(8'h7E, 1'b1, ^8'h7E);
        rx_full = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (n_ovr - o0 !== 1) begin
            failures++;
            $display("FAIL ovr_cnt got=%0d exp=1", n_ovr - o0);
        end
        checks++;
        if (n_valid - v0 !== 0 || rx_data !== 8'hA5) begin
            failures++;
            $display("FAIL ovr_keep got=%0d/%h exp=0/a5",
                n_valid - v0, rx_data);
        end
        send_frame(8'h81, 1'b1, ^8'h81);
        repeat (8) @(negedge clk);
        checks++;
        if (n_valid - v0 !== 1 || rx_data !== 8'h81) begin
            failures++;
            $display("FAIL ovr_next got=%0d/%h exp=1/81",
                n_valid - v0, rx_data);
        end
    endtask

    task automatic test_break();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        rxd = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        checks++;
        if (n_ferr - f0 !== 1) begin
            failures++;
            $display("FAIL brk_ferr got=%0d exp=1", n_ferr - f0);
        end
        checks++;
        if (busy !== 1'b0 || n_valid - v0 !== 0) begin
            failures++;
            $display("FAIL brk_idle got=%b/%0d exp=0/0",
                busy, n_valid - v0);
        end
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0, p0;
        v0 = n_valid;
        p0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        checks++;
        if (n_perr - p0 !== 1 || n_valid - v0 !== 0) begin
            failures++;
            $display("FAIL par_bad got=%0d/%0d exp=1/0",
                n_perr - p0, n_valid - v0);
        end
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if (n_valid - v0 !== 1 || rx_data !== 8'h07) begin
            failures++;
            $display("FAIL par_good got=%0d/%h exp=1/07",
                n_valid - v0, rx_data);
        end
    endtask
`else
    task automatic test_parity();
        checks++;
        if (n_perr !== 0) begin
            failures++;
            $display("FAIL par_off got=%0d exp=0", n_perr);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int v0, e0;
        v0 = n_valid;
        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        repeat (4) @(negedge clk);
        checks++;
        if (n_valid - v0 !== 2) begin
            failures++;
            $display("FAIL b2b_cnt got=%0d exp=2", n_valid - v0);
        end
        checks++;
        if (vq.size() < v0 + 2 || vq[v0] !== 8'h00
            || vq[v0 + 1] !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_data got=%h exp=ff", rx_data);
        end
        v0 = n_valid;
        e0 = n_ferr + n_ovr + n_perr;
        rxd = 1'b0;
        repeat (3 * BIT + 40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rxd = 1'b1;
        checks++;
        if (rx_data !== 8'h00 || {rx_valid, frame_err, overrun_err,
            parity_err, busy} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid got=%h/%b exp=00/00000", rx_data,
                {rx_valid, frame_err, overrun_err, parity_err, busy});
        end
        repeat (12 * BIT) @(negedge clk);
        checks++;
        if (n_valid - v0 !== 0 || n_ferr + n_ovr + n_perr - e0 !== 0
            || rx_data !== 8'h00) begin
            failures++;
            $display("FAIL rst_quiet got=%0d/%h exp=0/00",
                n_valid - v0, rx_data);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        rxd = 1'b1;
        rx_full = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_break();
        test_parity();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
